wallace_cpa_seq: RTL and testbench
==================================

Name: wallace_cpa_seq

Overview:
- Final carry-propagate stage of the Booth-4 / Wallace multiplier. It sits directly downstream of the n-to-2 operand reduction tree.
- It accepts the two redundant operands the tree produces (sum/carry rows) and adds them sequentially, CHUNK_WIDTH bits per cycle, rippling a registered carry between chunks.
- The final product is delivered over a valid/ready handshake. This bounds the adder's critical path independently of OP_WIDTH.

Parameters:
- OP_WIDTH, 64, width of each input operand and of the result.
- CHUNK_WIDTH, 16, bits added per cycle. Must divide OP_WIDTH exactly; elaboration fails otherwise.
- Derived localparam NCHUNK = OP_WIDTH / CHUNK_WIDTH, the number of add cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  in_op0/in_op1 hold a valid operand pair.
- in_ready  output  1  block can accept an operand pair.
- in_op0  input  OP_WIDTH  reduction-tree output row 0.
- in_op1  input  OP_WIDTH  reduction-tree output row 1.
- out_valid  output  1  out_sum/out_carry valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  OP_WIDTH  (in_op0 + in_op1) mod 2^OP_WIDTH.
- out_carry  output  1  carry out of bit OP_WIDTH-1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; chunk counter, carry register, operand registers, out_sum and out_carry all 0; out_valid=0.
  - in_ready reads 1 while in IDLE, including during reset.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid & in_ready at an edge: latch in_op0/in_op1, clear carry, clear counter idx, go to ADD.
  - ADD: in_ready=0, out_valid=0. Each edge computes {c, r} = op0[idx chunk] + op1[idx chunk] + carry (CHUNK_WIDTH+1 bits). r is written to result chunk idx, carry<=c, idx++. On the edge where idx==NCHUNK-1, set out_carry<=c and go to DONE.
  - DONE: out_valid=1, in_ready=0; out_sum/out_carry held stable. On out_valid & out_ready at an edge, go to IDLE.
- Latency:
  - A handshake accepted at edge k gives out_valid=1 after edge k+NCHUNK.
  - NCHUNK=1 gives single-cycle latency.
  - Minimum initiation interval is NCHUNK+2 cycles: accept, NCHUNK adds, DONE handshake, return to IDLE.
- Arithmetic:
  - Unsigned modular add. Signed (two's complement) products are correct in out_sum; out_carry is informational for signed use.
  - Chunk 0 occupies bits [CHUNK_WIDTH-1:0]; chunks proceed LSB first.
- Boundary conditions:
  - in_valid while in ADD/DONE: ignored; inputs are not sampled. The upstream holds data until in_ready.
  - out_ready high outside DONE: no effect.
  - out_ready held low in DONE: result held indefinitely, no overwrite.
  - in_op0/in_op1 changing after acceptance: no effect on the result.
  - rst_n asserted mid-ADD or in DONE: the in-flight result is discarded immediately and out_valid drops asynchronously. After release the block is in IDLE with in_ready=1.
  - Carry ripple across all chunks (all-ones + 1) is handled through the registered carry.
  - Counter width is $clog2(NCHUNK), minimum 1 bit.

Test Plan:
- Reset (OP_WIDTH=64, CHUNK_WIDTH=16) -> during and after reset: out_valid=0, out_sum=0, out_carry=0, in_ready=1.
- Carry into chunk 1: in_op0=0x0000_0000_0000_FFFF, in_op1=0x1 accepted at edge k -> out_valid=1 after edge k+4, out_sum=0x0000_0000_0001_0000, out_carry=0.
- Full ripple: in_op0=0xFFFF_FFFF_FFFF_FFFF, in_op1=0x1 -> out_sum=0, out_carry=1.
- Signed check: in_op0=0xFFFF_FFFF_FFFF_FFFE (-2), in_op1=0x5 -> out_sum=0x3, out_carry=1.
- Backpressure: out_ready=0 for 6 cycles in DONE with in_valid=1 and new operand values -> out_valid stays 1, out_sum unchanged, in_ready=0. Drop out_ready to 1 -> handshake, IDLE next cycle, new pair accepted, result correct.
- Reset mid-ADD: assert rst_n low 2 cycles after acceptance -> out_valid=0 immediately. After release, in_op0=0x1234, in_op1=0x4321 -> out_sum=0x5555 after 4 cycles. Repeat the same case with CHUNK_WIDTH=64 -> latency 1 cycle.

Source files
------------

// File: rtl/wallace_cpa_seq_if.sv
// ---------------------------------------------------------------------------
// wallace_cpa_seq_if
//   Operand/result handshake bundle for the sequential carry-propagate adder.
//
//   in_valid  : upstream holds a valid operand pair on in_op0/in_op1
//   in_ready  : adder can accept an operand pair
//   in_op0    : reduction-tree output row 0 (OP_WIDTH bits)
//   in_op1    : reduction-tree output row 1 (OP_WIDTH bits)
//   out_valid : out_sum/out_carry hold a finished result
//   out_ready : consumer accepts the result
//   out_sum   : (in_op0 + in_op1) mod 2^OP_WIDTH
//   out_carry : carry out of bit OP_WIDTH-1
//
//   Modport slave is the adder side, master is the producer/consumer side.
// ---------------------------------------------------------------------------
interface wallace_cpa_seq_if #(
    parameter int OP_WIDTH = 64
);
    logic                in_valid;
    logic                in_ready;
    logic [OP_WIDTH-1:0] in_op0;
    logic [OP_WIDTH-1:0] in_op1;
    logic                out_valid;
    logic                out_ready;
    logic [OP_WIDTH-1:0] out_sum;
    logic                out_carry;

    modport slave (
        input  in_valid,
        input  in_op0,
        input  in_op1,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_carry
    );

    modport master (
        output in_valid,
        output in_op0,
        output in_op1,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_carry
    );
endinterface

// File: rtl/wallace_cpa_seq.sv
// ---------------------------------------------------------------------------
// wallace_cpa_seq
//   Final carry-propagate stage of the Booth-4 / Wallace multiplier. Adds the
//   sum/carry rows from the reduction tree CHUNK_WIDTH bits per cycle, LSB
//   chunk first, rippling a registered carry between chunks, so the adder's
//   critical path depends on CHUNK_WIDTH only.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : wallace_cpa_seq_if.slave (operand input / result output
//             valid-ready handshakes, see the interface file)
//
//   Latency: a pair accepted at edge k is presented with out_valid=1 after
//   edge k+NCHUNK, and held until the consumer takes it.
// ---------------------------------------------------------------------------
module wallace_cpa_seq #(
    parameter int OP_WIDTH    = 64,
    parameter int CHUNK_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wallace_cpa_seq_if.slave      bus
);

    localparam int NCHUNK = OP_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int SEL_W  = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    // A partial last chunk would silently drop the top bits, so refuse it.
    if ((OP_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_chunk
        $error("wallace_cpa_seq: CHUNK_WIDTH must divide OP_WIDTH exactly");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One chunk of the ripple: {carry_out, sum} of a + b + carry_in.
    function automatic logic [CHUNK_WIDTH:0] chunk_add(
        input logic [CHUNK_WIDTH-1:0] a,
        input logic [CHUNK_WIDTH-1:0] b,
        input logic                   cin
    );
        return {1'b0, a} + {1'b0, b} + {{CHUNK_WIDTH{1'b0}}, cin};
    endfunction

    state_t                 state_r;
    state_t                 state_s;
    logic [IDX_W-1:0]       idx_r;
    logic                   carry_r;
    logic [OP_WIDTH-1:0]    op0_r;
    logic [OP_WIDTH-1:0]    op1_r;
    logic [OP_WIDTH-1:0]    sum_r;
    logic                   out_carry_r;
    logic [SEL_W-1:0]       base_s;
    logic [CHUNK_WIDTH:0]   add_s;

    // Handshake flags decode straight from the state register so that an
    // asynchronous reset drops out_valid and raises in_ready immediately.
    assign bus.in_ready  = (state_r == ST_IDLE);
    assign bus.out_valid = (state_r == ST_DONE);
    assign bus.out_sum   = sum_r;
    assign bus.out_carry = out_carry_r;

    // Bit offset of the chunk being added and its chunk sum.
    always_comb begin
        base_s = SEL_W'(idx_r) * SEL_W'(CHUNK_WIDTH);
        add_s  = chunk_add(op0_r[base_s +: CHUNK_WIDTH],
                           op1_r[base_s +: CHUNK_WIDTH],
                           carry_r);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_s = ST_ADD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (idx_r == LAST_IDX) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ADD;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture in IDLE, one chunk per edge in ADD; the
    // result registers are only written in ADD, so DONE holds them stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= '0;
            carry_r     <= 1'b0;
            op0_r       <= '0;
            op1_r       <= '0;
            sum_r       <= '0;
            out_carry_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op0_r   <= bus.in_op0;
                        op1_r   <= bus.in_op1;
                        carry_r <= 1'b0;
                        idx_r   <= '0;
                    end
                end
                ST_ADD: begin
                    sum_r[base_s +: CHUNK_WIDTH] <= add_s[CHUNK_WIDTH-1:0];
                    carry_r <= add_s[CHUNK_WIDTH];
                    idx_r   <= idx_r + IDX_W'(1);
                    if (idx_r == LAST_IDX) begin
                        out_carry_r <= add_s[CHUNK_WIDTH];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wallace_cpa_seq.sv
// ---------------------------------------------------------------------------
// tb_wallace_cpa_seq
//   Directed bench for wallace_cpa_seq: a 4-chunk instance (64/16) and a
//   single-chunk instance (64/64) share clock and reset; sel_b picks which
//   one the stimulus tasks drive and observe.
// ---------------------------------------------------------------------------
module tb_wallace_cpa_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    bit          sel_b = 1'b0;
    logic        drv_valid = 1'b0;
    logic        drv_ready = 1'b0;
    logic [63:0] drv_op0 = 64'd0;
    logic [63:0] drv_op1 = 64'd0;

    logic        obs_valid;
    logic        obs_ready;
    logic [63:0] obs_sum;
    logic        obs_carry;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wallace_cpa_seq_if #(.OP_WIDTH(64)) bus_a ();
    wallace_cpa_seq_if #(.OP_WIDTH(64)) bus_b ();

    assign bus_a.in_valid  = sel_b ? 1'b0 : drv_valid;
    assign bus_a.out_ready = sel_b ? 1'b0 : drv_ready;
    assign bus_a.in_op0    = drv_op0;
    assign bus_a.in_op1    = drv_op1;
    assign bus_b.in_valid  = sel_b ? drv_valid : 1'b0;
    assign bus_b.out_ready = sel_b ? drv_ready : 1'b0;
    assign bus_b.in_op0    = drv_op0;
    assign bus_b.in_op1    = drv_op1;

    assign obs_valid = sel_b ? bus_b.out_valid : bus_a.out_valid;
    assign obs_ready = sel_b ? bus_b.in_ready  : bus_a.in_ready;
    assign obs_sum   = sel_b ? bus_b.out_sum   : bus_a.out_sum;
    assign obs_carry = sel_b ? bus_b.out_carry : bus_a.out_carry;

    wallace_cpa_seq #(.OP_WIDTH(64), .CHUNK_WIDTH(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    wallace_cpa_seq #(.OP_WIDTH(64), .CHUNK_WIDTH(64)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    // Present a pair, wait (bounded) for in_ready, return #1 after the
    // accepting edge with the operand lines scrambled.
    task automatic accept(input logic [63:0] a, input logic [63:0] b);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        drv_valid = 1'b1;
        drv_op0   = a;
        drv_op1   = b;
        for (int i = 0; i < 20; i++) begin
            if (obs_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_ready: in_ready=%0b required 1", obs_ready);
        end
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        drv_op0   = ~a;
        drv_op1   = ~b;
    endtask

    // out_valid must stay low for nchunk-1 edges and rise after edge nchunk.
    task automatic wait_result(input int nchunk, input string name);
        logic exp_v;
        for (int i = 1; i <= nchunk; i++) begin
            @(posedge clk);
            #1;
            exp_v = (i == nchunk) ? 1'b1 : 1'b0;
            total++;
            if (obs_valid !== exp_v) begin
                bad++;
                $display("FAIL %s_latency edge+%0d: out_valid=%0b required %0b",
                         name, i, obs_valid, exp_v);
            end
        end
    endtask

    task automatic check_result(input logic [63:0] exp_sum, input logic exp_c,
                                input string name);
        total++;
        if (obs_sum !== exp_sum) begin
            bad++;
            $display("FAIL %s_sum: got %h required %h", name, obs_sum, exp_sum);
        end
        total++;
        if (obs_carry !== exp_c) begin
            bad++;
            $display("FAIL %s_carry: got %0b required %0b", name, obs_carry, exp_c);
        end
    endtask

    // Take the result and confirm the return to IDLE.
    task automatic handshake(input string name);
        @(negedge clk);
        drv_ready = 1'b1;
        @(posedge clk);
        #1;
        drv_ready = 1'b0;
        total++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_handshake: out_valid=%0b in_ready=%0b required 0/1",
                     name, obs_valid, obs_ready);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_flags: out_valid=%0b in_ready=%0b required 0/1",
                     obs_valid, obs_ready);
        end
        check_result(64'd0, 1'b0, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_after: out_valid=%0b in_ready=%0b required 0/1",
                     obs_valid, obs_ready);
        end
    endtask

    task automatic test_add(input logic [63:0] a, input logic [63:0] b,
                            input int nchunk, input logic [63:0] exp_sum,
                            input logic exp_c, input string name);
        accept(a, b);
        wait_result(nchunk, name);
        check_result(exp_sum, exp_c, name);
        handshake(name);
    endtask

    task automatic test_backpressure();
        accept(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222);
        wait_result(4, "bp_first");
        check_result(64'h3333_3333_3333_3333, 1'b0, "bp_first");
        @(negedge clk);
        drv_valid = 1'b1;
        drv_op0   = 64'hAAAA_AAAA_AAAA_AAAA;
        drv_op1   = 64'h5555_5555_5555_5556;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (obs_valid !== 1'b1 || obs_ready !== 1'b0 ||
                obs_sum !== 64'h3333_3333_3333_3333) begin
                bad++;
                $display("FAIL bp_hold cycle %0d: out_valid=%0b in_ready=%0b sum=%h required 1/0/3333333333333333",
                         i, obs_valid, obs_ready, obs_sum);
            end
        end
        @(negedge clk);
        drv_ready = 1'b1;
        @(posedge clk);
        #1;
        drv_ready = 1'b0;
        total++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: out_valid=%0b in_ready=%0b required 0/1",
                     obs_valid, obs_ready);
        end
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        drv_op0   = 64'd0;
        drv_op1   = 64'd0;
        total++;
        if (obs_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_second_accept: in_ready=%0b required 0", obs_ready);
        end
        wait_result(4, "bp_second");
        check_result(64'd0, 1'b1, "bp_second");
        handshake("bp_second");
    endtask

    // Reset nchunk-dependent distance into the transaction, then a clean add.
    task automatic test_reset_mid_add(input int nchunk, input string name);
        accept(64'h1234, 64'h4321);
        repeat (2) @(posedge clk);
        #1;
        if (nchunk == 1) begin
            total++;
            if (obs_valid !== 1'b1) begin
                bad++;
                $display("FAIL %s_pre_reset: out_valid=%0b required 1", name, obs_valid);
            end
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_sum !== 64'd0) begin
            bad++;
            $display("FAIL %s_async: out_valid=%0b in_ready=%0b sum=%h required 0/1/0",
                     name, obs_valid, obs_ready, obs_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_add(64'h1234, 64'h4321, nchunk, 64'h5555, 1'b0, name);
    endtask

    task automatic test_reset_in_done();
        accept(64'hFFFF, 64'h1);
        wait_result(4, "rst_done");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_done_async: out_valid=%0b in_ready=%0b required 0/1",
                     obs_valid, obs_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add(64'h0000_0000_0000_FFFF, 64'h1, 4,
                 64'h0000_0000_0001_0000, 1'b0, "carry_chunk1");
        test_add(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4, 64'd0, 1'b1, "full_ripple");
        test_add(64'hFFFF_FFFF_FFFF_FFFE, 64'h5, 4, 64'h3, 1'b1, "signed");
        test_backpressure();
        test_reset_mid_add(4, "mid_add16");
        test_reset_in_done();
        sel_b = 1'b1;
        test_reset_mid_add(1, "mid_add64");
        test_add(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1, 64'd0, 1'b1, "ripple64");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
